// File: rtl/scan_mux_if.sv
// rtl/scan_mux_if.sv - control, channel data and selected-output bundle for scan_mux
interface scan_mux_if #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 2
);
    localparam int CHANNELS = 2 ** SEL_W;

    logic                      En;
    logic                      mode;
    logic [SEL_W-1:0]          s;
    logic [CHANNELS*WIDTH-1:0] w;
    logic [WIDTH-1:0]          f;
    logic [SEL_W-1:0]          ch;
    logic [CHANNELS-1:0]       dec;
    logic                      valid;
    logic                      wrap;

    modport master (
        output En, mode, s, w,
        input  f, ch, dec, valid, wrap
    );

    modport slave (
        input  En, mode, s, w,
        output f, ch, dec, valid, wrap
    );
endinterface

// File: rtl/scan_mux.sv
// rtl/scan_mux.sv - registered N-way mux with manual select or dwell-timed auto-scan
// Define SCAN_MUX_REVERSE_EN to map channel index 0 onto the top data slot.
module scan_mux #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input  logic         Clock,
    input  logic         Resetn,
    scan_mux_if.slave    bus
);
    localparam int CHANNELS = 2 ** SEL_W;
    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

    state_t           state;
    logic [WIDTH-1:0] f_q, f_next;
    logic [SEL_W-1:0] ch_q, ch_next;
    logic [7:0]       cnt_q, cnt_next;
    logic             valid_q, valid_next;
    logic             wrap_q, wrap_next;

    function automatic logic [WIDTH-1:0] slot(input logic [CHANNELS*WIDTH-1:0] data,
                                              input logic [SEL_W-1:0] k);
        logic [SEL_W-1:0] idx;
`ifdef SCAN_MUX_REVERSE_EN
        idx = ~k;
`else
        idx = k;
`endif
        return data[idx*WIDTH +: WIDTH];
    endfunction

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            f_q     <= '0;
            ch_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            f_q     <= f_next;
            ch_q    <= ch_next;
            cnt_q   <= cnt_next;
            valid_q <= valid_next;
            wrap_q  <= wrap_next;
        end
    end

    always_comb begin
        state      = IDLE;
        f_next     = f_q;
        ch_next    = ch_q;
        cnt_next   = cnt_q;
        valid_next = 1'b0;
        wrap_next  = 1'b0;
        if (bus.En) state = bus.mode ? SCAN : MANUAL;
        case (state)
            MANUAL: begin
                ch_next    = bus.s;
                cnt_next   = '0;
                f_next     = slot(bus.w, bus.s);
                valid_next = 1'b1;
            end
            SCAN: begin
                if (cnt_q >= DWELL_LAST) begin
                    ch_next   = ch_q + SEL_W'(1);
                    cnt_next  = '0;
                    wrap_next = (ch_q == '1);
                end else begin
                    cnt_next  = cnt_q + 8'd1;
                end
                // Data is re-sampled every cycle so a held channel still tracks w.
                f_next     = slot(bus.w, ch_next);
                valid_next = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.f     = f_q;
    assign bus.ch    = ch_q;
    assign bus.dec   = {{(CHANNELS-1){1'b0}}, 1'b1} << ch_q;
    assign bus.valid = valid_q;
    assign bus.wrap  = wrap_q;
endmodule

// File: doc/scan_mux.md
SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bits per channel.
REQ-002 SHALL have parameter SEL_W, default 2: select width; CHANNELS = 2**SEL_W.
REQ-003 SHALL have parameter DWELL, default 4: cycles per channel in scan mode, legal range 1..255.
REQ-004 SHALL have port Clock, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port Resetn, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port En, input, 1: enable; low freezes selection state.
REQ-007 SHALL have port mode, input, 1: 0 = manual select, 1 = auto-scan.
REQ-008 SHALL have port s, input, SEL_W: manual channel select.
REQ-009 SHALL have port w, input, CHANNELS*WIDTH: packed channel data.
REQ-010 SHALL have port f, output, WIDTH: registered selected data.
REQ-011 SHALL have port ch, output, SEL_W: channel index currently driving f.
REQ-012 SHALL have port dec, output, CHANNELS: one-hot decode of ch.
REQ-013 SHALL have port valid, output, 1: f/ch/dec updated this cycle.
REQ-014 SHALL have port wrap, output, 1: one-cycle pulse when scan leaves channel CHANNELS-1.

Function
REQ-015 SHALL implement states IDLE (En=0), MANUAL (En=1, mode=0) and SCAN (En=1, mode=1), re-evaluated every cycle.
REQ-016 SHALL, in MANUAL, load ch <= s and f <= slot(s) each cycle, giving 1-cycle latency from s/w to f.
REQ-017 SHALL, in SCAN, hold ch for DWELL cycles via a dwell counter (width 8), then advance ch by 1 modulo CHANNELS and clear the counter.
REQ-018 SHALL, in SCAN, register f <= slot(ch_next) every cycle, so data changes on held channels are tracked with 1-cycle latency.
REQ-019 SHALL pulse wrap for exactly the cycle in which ch changes from CHANNELS-1 to 0; wrap SHALL be 0 in MANUAL and IDLE.
REQ-020 SHALL, on a MANUAL-to-SCAN transition, start scanning from the current ch with the dwell counter at 0.
REQ-021 SHALL, on a SCAN-to-MANUAL transition, take s on that same edge and clear the dwell counter.
REQ-022 SHALL, in IDLE, hold f, ch, dec and the dwell counter, and drive valid = 0 and wrap = 0.
REQ-023 SHALL drive valid = 1 on every cycle following an edge in MANUAL or SCAN.
REQ-024 SHALL always drive dec as exactly one-hot, matching ch, including during and after reset.
REQ-025 SHALL, with DWELL = 1, advance ch every cycle in SCAN.
REQ-026 SHALL, with SEL_W = 1, wrap between channels 0 and 1 only.
REQ-027 SHALL define slot(k) as w[k*WIDTH +: WIDTH], unless modified by REQ-032.

Reset
REQ-028 SHALL, when Resetn = 0, immediately force f = 0, ch = 0, dec = 1 (bit 0 set), valid = 0, wrap = 0, dwell counter = 0, independent of Clock.
REQ-029 SHALL, after Resetn deasserts, act on the first rising Clock edge.
REQ-030 SHALL, on reset during a scan, restart the scan from channel 0 with a full DWELL period.

Configuration
REQ-031 SHALL provide macro SCAN_MUX_REVERSE_EN.
REQ-032 SHALL, when SCAN_MUX_REVERSE_EN is defined, define slot(k) as w[(CHANNELS-1-k)*WIDTH +: WIDTH], so index 0 selects the top slot; ch, dec and wrap SHALL be unchanged.
REQ-033 SHALL, when SCAN_MUX_REVERSE_EN is undefined, use ascending mapping per REQ-027.

Verification
REQ-034 SHALL cover manual select: WIDTH=8, SEL_W=2, w={8'h44,8'h33,8'h22,8'h11}, mode=0, s=2 -> next cycle f=8'h33, ch=2, dec=4'b0100, valid=1.
REQ-035 SHALL cover scan: DWELL=4, mode=1 from reset -> ch sequence 0,0,0,0,1,1,1,1,2,...; wrap=1 only on the 3->0 edge, i.e. every 16 cycles.
REQ-036 SHALL cover enable hold: deassert En mid-dwell (counter=2) for 5 cycles -> f/ch frozen, valid=0; on re-enable, ch advances after 2 more cycles.
REQ-037 SHALL cover mid-scan reset: pull Resetn low with ch=3 without a clock edge -> f=0, ch=0, dec=4'b0001 immediately; scan then restarts at 0 with 4-cycle dwell.
REQ-038 SHALL cover mode switch: scanning at ch=1, switch mode=0 with s=3 -> next cycle ch=3, f=slot(3); switching back to mode=1 resumes from 3.
REQ-039 SHALL cover the reverse build: SCAN_MUX_REVERSE_EN defined, same w as REQ-034, s=0 -> f=8'h44.
